// File: rtl/wf_player_pkg.sv
// wf_dac_player shared types.
// State encoding, I/Q slices and FIFO entry layout.
package wf_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ARMED,
    ST_PLAY,
    ST_FLUSH
  } state_e;

  localparam int ENTRY_W   = 33;
  localparam int TLAST_BIT = 32;
  localparam int I_HI      = 31;
  localparam int I_LO      = 16;
  localparam int Q_HI      = 15;
  localparam int Q_LO      = 0;

endpackage

// File: rtl/wf_sample_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Flush empties it in one cycle and wins over a write.
module wf_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full & ~flush;
  assign do_rd   = rd_en & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/wf_dac_player.sv
// Buffers a replayed waveform and plays one I/Q sample per clock
// on trigger, enforcing length and flagging underflow/framing.
module wf_dac_player
  import wf_player_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_in1,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic [31:0]          wf_length,
  input  logic                 trigger,
  input  logic                 clear_status,
  input  logic [31:0]          wfin_axis_tdata,
  input  logic                 wfin_axis_tvalid,
  input  logic                 wfin_axis_tlast,
  output logic                 wfin_axis_tready,
  output logic [15:0]          dac_out_i,
  output logic [15:0]          dac_out_q,
  output logic                 dac_out_valid,
  output logic                 armed,
  output logic                 play_active,
  output logic                 play_done,
  output logic                 underflow,
  output logic                 length_err,
  output logic [CNT_WIDTH-1:0] underflow_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q;
  state_e             state_d;
  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      tl_cnt_q;
  logic [31:0]        len_q;
  logic [31:0]        cnt_q;
  logic               tl_seen_q;
  logic               tl_seen_d;
  logic               accept;
  logic               wr_en;
  logic               pop;
  logic               flush;
  logic               head_last;
  logic               last_smp;
  logic               start;
  logic               set_uf;
  logic               set_le;
  logic               done_d;
  logic               smp_valid;
  logic [31:0]        smp_data;

  assign wfin_axis_tready = (state_q == ST_FLUSH) | ~fifo_full;
  assign accept    = wfin_axis_tvalid & wfin_axis_tready;
  assign wr_en     = accept & (state_q != ST_FLUSH);
  assign head_last = head[TLAST_BIT];
  assign last_smp  = (cnt_q == len_q - 32'd1);
  assign armed     = (state_q == ST_ARMED);
  assign play_active = (state_q == ST_PLAY);

  wf_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk_in1),
    .rst_n   (aresetn),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data ({wfin_axis_tlast, wfin_axis_tdata}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    tl_seen_d = tl_seen_q;
    pop       = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
    set_uf    = 1'b0;
    set_le    = 1'b0;
    done_d    = 1'b0;
    smp_valid = 1'b0;
    smp_data  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (fifo_count >= CW'(PRIME_LEVEL) || tl_cnt_q != '0)
          state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trigger) begin
          if (wf_length == '0) begin
            done_d  = 1'b1;
            state_d = ST_PRIME;
          end else begin
            start     = 1'b1;
            tl_seen_d = 1'b0;
            state_d   = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        smp_valid = 1'b1;
        // after tlast the frame is over: zero-fill without popping
        if (!tl_seen_q) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            smp_data = head[31:0];
            if (head_last) begin
              tl_seen_d = 1'b1;
              if (!last_smp) set_le = 1'b1;
            end
          end else begin
            set_uf = 1'b1;
          end
        end
        if (last_smp) begin
          done_d = 1'b1;
          if (tl_seen_d) begin
            state_d = ST_PRIME;
          end else begin
            set_le  = 1'b1;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        pop = ~fifo_empty;
        if ((pop && head_last) || (accept && wfin_axis_tlast)) begin
          flush   = 1'b1;
          state_d = ST_PRIME;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d   = ST_IDLE;
      flush     = 1'b1;
      pop       = 1'b0;
      start     = 1'b0;
      set_uf    = 1'b0;
      set_le    = 1'b0;
      done_d    = 1'b0;
      smp_valid = 1'b0;
      smp_data  = '0;
    end
  end

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      tl_seen_q <= 1'b0;
      tl_cnt_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tl_seen_q <= tl_seen_d;
      if (flush) tl_cnt_q <= '0;
      else tl_cnt_q <= tl_cnt_q + CW'(wr_en & wfin_axis_tlast)
                               - CW'(pop & head_last);
      if (start) begin
        len_q <= wf_length;
        cnt_q <= '0;
      end else if (state_q == ST_PLAY) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      dac_out_i       <= '0;
      dac_out_q       <= '0;
      dac_out_valid   <= 1'b0;
      play_done       <= 1'b0;
      underflow       <= 1'b0;
      length_err      <= 1'b0;
      underflow_count <= '0;
    end else begin
      dac_out_i     <= smp_data[I_HI:I_LO];
      dac_out_q     <= smp_data[Q_HI:Q_LO];
      dac_out_valid <= smp_valid;
      play_done     <= done_d;
      if (clear_status) underflow <= 1'b0;
      else if (set_uf) underflow <= 1'b1;
      if (clear_status) length_err <= 1'b0;
      else if (set_le) length_err <= 1'b1;
      if (clear_status) underflow_count <= '0;
      else if (set_uf && underflow_count != '1)
        underflow_count <= underflow_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_wf_dac_player.sv
// Directed bench for wf_dac_player.
// Checks playback, framing, underflow, length-0 and reset abort.
module tb_wf_dac_player;

  logic        clk_in1 = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] wf_length = '0;
  logic        trigger = 1'b0;
  logic        clear_status = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [15:0] dac_out_i;
  logic [15:0] dac_out_q;
  logic        dac_out_valid;
  logic        armed;
  logic        play_active;
  logic        play_done;
  logic        underflow;
  logic        length_err;
  logic [15:0] underflow_count;

  int checks = 0;
  int errors = 0;
  int nsamp, done_at, idx, zf, bad, extra;
  bit abort = 1'b0;

  always #5 clk_in1 = ~clk_in1;

  wf_dac_player #(
    .FIFO_DEPTH  (16),
    .PRIME_LEVEL (8),
    .CNT_WIDTH   (16)
  ) dut (
    .clk_in1          (clk_in1),
    .aresetn          (aresetn),
    .enable           (enable),
    .wf_length        (wf_length),
    .trigger          (trigger),
    .clear_status     (clear_status),
    .wfin_axis_tdata  (tdata),
    .wfin_axis_tvalid (tvalid),
    .wfin_axis_tlast  (tlast),
    .wfin_axis_tready (tready),
    .dac_out_i        (dac_out_i),
    .dac_out_q        (dac_out_q),
    .dac_out_valid    (dac_out_valid),
    .armed            (armed),
    .play_active      (play_active),
    .play_done        (play_done),
    .underflow        (underflow),
    .length_err       (length_err),
    .underflow_count  (underflow_count)
  );

  function automatic logic [31:0] word(input int i);
    logic [15:0] v;
    v = i[15:0];
    return {v, 16'h8000 | v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int first, input int n, input bit wl,
                            input int fast, input int gap);
    int i = first;
    int guard = 0;
    while (i < n && !abort && guard < 5000) begin
      @(negedge clk_in1);
      guard++;
      tvalid = 1'b1;
      tdata  = word(i);
      tlast  = wl && (i == n - 1);
      if (tready) begin
        i++;
        if (i >= fast)
          repeat (gap - 1) begin
            @(negedge clk_in1);
            tvalid = 1'b0;
          end
      end
    end
    @(negedge clk_in1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic arm_and_trigger(input string tag, input int max_cyc);
    int c = 0;
    do begin
      @(negedge clk_in1);
      c++;
    end while (!armed && c < max_cyc);
    chk(tag, armed, 1);
    trigger = 1'b1;
    @(negedge clk_in1);
    trigger = 1'b0;
  endtask

  task automatic collect(input int max_cyc, input int stop_at,
                         input int retrig_at);
    nsamp = 0; done_at = -1; idx = 0; zf = 0; bad = 0; extra = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_in1);
      if (dac_out_valid) begin
        if ({dac_out_i, dac_out_q} === word(idx)) idx++;
        else if ({dac_out_i, dac_out_q} === 32'h0) zf++;
        else bad++;
        nsamp++;
      end
      trigger = (nsamp == retrig_at);
      if (play_done) begin
        done_at = dac_out_valid ? nsamp - 1 : -2;
        break;
      end
      if (nsamp == stop_at) break;
    end
    trigger = 1'b0;
    if (stop_at < 0)
      repeat (3) begin
        @(negedge clk_in1);
        if (dac_out_valid) extra++;
      end
  endtask

  task automatic check_play(input string tag, input int n,
                            input int i_exp, input int z_exp);
    chk({tag, "_nsamp"}, nsamp, n);
    chk({tag, "_done_at"}, done_at, n - 1);
    chk({tag, "_in_order"}, idx, i_exp);
    chk({tag, "_zero_fill"}, zf, z_exp);
    chk({tag, "_bad"}, bad, 0);
    chk({tag, "_extra_valid"}, extra, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk_in1);
    clear_status = 1'b1;
    @(negedge clk_in1);
    clear_status = 1'b0;
    chk("clear_flags", {underflow, length_err, underflow_count}, 0);
  endtask

  initial begin
    int v;
    repeat (3) @(negedge clk_in1);
    chk("rst_outputs", {dac_out_i, dac_out_q, dac_out_valid, armed,
        play_active, play_done, underflow, length_err}, 0);
    chk("rst_ucount", underflow_count, 0);
    chk("rst_tready", tready, 1);
    aresetn = 1'b1;
    enable = 1'b1;

    // early trigger with 3 words is ignored, then normal 128
    wf_length = 128;
    send_frame(0, 3, 1'b0, 1000, 1);
    repeat (3) @(negedge clk_in1);
    chk("early_not_armed", armed, 0);
    trigger = 1'b1;
    @(negedge clk_in1);
    trigger = 1'b0;
    v = 0;
    repeat (4) begin
      @(negedge clk_in1);
      if (dac_out_valid || play_done || play_active) v++;
    end
    chk("early_trig_ignored", v, 0);
    fork
      send_frame(3, 128, 1'b1, 1000, 1);
      begin
        arm_and_trigger("normal_armed", 100);
        collect(400, -1, -1);
      end
    join
    check_play("normal", 128, 128, 0);
    chk("normal_flags", {underflow, length_err, underflow_count}, 0);
    chk("normal_to_prime", {armed, play_active}, 0);

    // trigger during PLAY is ignored
    wf_length = 32;
    fork
      send_frame(0, 32, 1'b1, 1000, 1);
      begin
        arm_and_trigger("retrig_armed", 100);
        collect(200, -1, 10);
      end
    join
    check_play("retrig", 32, 32, 0);
    chk("retrig_len_err", length_err, 0);

    // wf_length=0 pulses done without popping, then plays 8
    wf_length = 0;
    send_frame(0, 8, 1'b1, 1000, 1);
    arm_and_trigger("len0_armed", 50);
    chk("len0_done", {play_done, dac_out_valid}, 2'b10);
    @(negedge clk_in1);
    chk("len0_done_end", {play_done, dac_out_valid}, 2'b00);
    wf_length = 8;
    arm_and_trigger("len8_armed", 50);
    collect(100, -1, -1);
    check_play("len8", 8, 8, 0);
    chk("len8_flags", {underflow, length_err}, 0);

    // underflow: throttled source, tlast never reached in time
    wf_length = 128;
    fork
      send_frame(0, 128, 1'b1, 8, 4);
      begin
        arm_and_trigger("uf_armed", 100);
        collect(400, -1, -1);
      end
    join
    chk("uf_nsamp", nsamp, 128);
    chk("uf_done_at", done_at, 127);
    chk("uf_total", idx + zf, 128);
    chk("uf_bad", bad, 0);
    chk("uf_flag", underflow, 1);
    chk("uf_count", underflow_count, zf);
    chk("uf_late_len_err", length_err, 1);
    pulse_clear();

    // early tlast on word 63
    fork
      send_frame(0, 64, 1'b1, 1000, 1);
      begin
        arm_and_trigger("early_tl_armed", 100);
        collect(400, -1, -1);
      end
    join
    check_play("early_tl", 128, 64, 64);
    chk("early_tl_flags", {underflow, length_err, underflow_count}, 17'h10000);
    pulse_clear();

    // late tlast: 200-word frame, tail flushed
    fork
      send_frame(0, 200, 1'b1, 1000, 1);
      begin
        arm_and_trigger("late_armed", 100);
        collect(400, -1, -1);
      end
    join
    check_play("late", 128, 128, 0);
    chk("late_flags", {underflow, length_err}, 2'b01);
    repeat (2) @(negedge clk_in1);
    chk("late_prime_empty", {armed, play_active}, 0);
    pulse_clear();
    wf_length = 16;
    fork
      send_frame(0, 16, 1'b1, 1000, 1);
      begin
        arm_and_trigger("post_flush_armed", 100);
        collect(100, -1, -1);
      end
    join
    check_play("post_flush", 16, 16, 0);

    // reset mid-PLAY at sample 40
    wf_length = 128;
    abort = 1'b0;
    fork
      send_frame(0, 128, 1'b1, 1000, 1);
      begin
        arm_and_trigger("rstp_armed", 100);
        collect(400, 40, -1);
        chk("rstp_reached", nsamp, 40);
        aresetn = 1'b0;
        abort = 1'b1;
        #1;
        chk("rstp_outputs", {dac_out_i, dac_out_q, dac_out_valid, armed,
            play_active, play_done, underflow, length_err}, 0);
        chk("rstp_ucount", underflow_count, 0);
      end
    join
    tvalid = 1'b0;
    tlast = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk_in1);
    chk("rstp_no_done", {play_done, dac_out_valid}, 0);
    aresetn = 1'b1;
    wf_length = 16;
    fork
      send_frame(0, 16, 1'b1, 1000, 1);
      begin
        arm_and_trigger("rstp_rearmed", 100);
        collect(100, -1, -1);
      end
    join
    check_play("rstp_replay", 16, 16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wf_dac_player.md
Name: wf_dac_player

Overview:
- Downstream consumer of the waveform_stream read port (wfout_axis).
- Buffers the replayed waveform in a small FIFO and plays it out as one I/Q DAC sample per clock when a trigger arrives (chirp_init-style pulse).
- Enforces the configured length and reports underflow and framing errors.
- Sits between waveform_stream and the DAC/DUC sample path, in the same clock domain.

Parameters:
- FIFO_DEPTH, 16, prefill FIFO depth in 32-bit words (power of 2, >=4)
- PRIME_LEVEL, 8, words buffered before ARMED is entered (<= FIFO_DEPTH)
- CNT_WIDTH, 16, width of the underflow counter

Ports:
- clk_in1  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  when low, state forced to IDLE at next edge, FIFO flushed
- wf_length  in  32  samples per playback, latched at trigger
- trigger  in  1  single-cycle start pulse
- clear_status  in  1  clears sticky flags and the counter
- wfin_axis_tdata  in  32  [31:16]=I, [15:0]=Q
- wfin_axis_tvalid  in  1  AXIS valid
- wfin_axis_tlast  in  1  last word of waveform frame
- wfin_axis_tready  out  1  AXIS ready
- dac_out_i  out  16  I sample
- dac_out_q  out  16  Q sample
- dac_out_valid  out  1  sample strobe
- armed  out  1  high in ARMED
- play_active  out  1  high in PLAY
- play_done  out  1  one-cycle pulse at end of playback
- underflow  out  1  sticky: FIFO empty during PLAY
- length_err  out  1  sticky: tlast position disagrees with wf_length
- underflow_count  out  CNT_WIDTH  saturating count of underflow cycles

Behaviour:
- Clock and reset: single clock clk_in1; reset is asynchronous, active-low on aresetn.
- Reset values:
  - All outputs 0, state IDLE, FIFO empty.
  - Reset mid-PLAY aborts immediately with no play_done.
- Input handshake:
  - wfin_axis_tready = FIFO not full AND state in {IDLE, PRIME, ARMED, PLAY}.
  - In FLUSH, tready=1 and words are discarded.
  - Word accepted on tvalid&tready. The tlast flag is stored alongside each word (33-bit FIFO entry).
- FSM:
  - IDLE -> PRIME when enable=1.
  - PRIME -> ARMED when FIFO count >= PRIME_LEVEL, or a buffered tlast exists.
  - ARMED + trigger:
    - wf_length==0: play_done pulses next cycle, go to PRIME, nothing popped.
    - Otherwise latch length, sample counter=0, go to PLAY.
  - PLAY: every cycle emits one sample, counter++. When counter reaches length-1 that cycle is the last sample; play_done pulses with it.
    - If the tlast word was popped: -> PRIME.
    - Else -> FLUSH.
  - FLUSH: discard input until an accepted word with tlast=1 (or a popped FIFO entry with tlast), then clear FIFO -> PRIME.
  - Trigger outside ARMED is ignored, including during PLAY.
- Latency: trigger sampled at edge k -> first dac_out_valid=1 registered at edge k+1. Outputs are registered, one pop per cycle.
- Underflow:
  - In PLAY with FIFO empty and tlast not yet popped: output I=Q=0, dac_out_valid=1, underflow=1, underflow_count++ (saturates at all-ones).
  - The sample counter still advances, so playback length is fixed.
- Early tlast (tlast popped before counter reaches length-1):
  - length_err=1, remaining samples output as zero.
  - No further pops; not counted as underflow.
- Late tlast (length reached, tlast not popped): length_err=1, enter FLUSH.
- dac_out_valid=0 and I/Q hold 0 outside PLAY.
- clear_status has priority over a simultaneous set of the same flag: clear wins this cycle, sets resume next cycle.
- enable low mid-PLAY: abort, no play_done, FIFO flushed, IDLE.

Decomposition:
- Shared package wf_player_pkg:
  - state encoding (IDLE, PRIME, ARMED, PLAY, FLUSH)
  - I/Q field slice constants
  - FIFO entry width (33)
- One sub-module: wf_sample_fifo. Synchronous FIFO with count output, async active-low reset, and a flush input.

Test Plan:
- Normal:
  - Stimulus: stream 128 words 0..127 with tlast on 127, wf_length=128, trigger once ARMED.
  - Response: exactly 128 valid samples in order; play_done coincides with sample 127; no flags; returns to PRIME.
- Early trigger: trigger while in PRIME with 3 words buffered -> ignored, no dac_out_valid; a later trigger in ARMED plays normally.
- Underflow:
  - Stimulus: throttle tvalid to 1-in-4 after prime, wf_length=128.
  - Response: 128 valid cycles total, underflow=1, underflow_count = number of zero-filled cycles; clear_status resets both.
- Framing:
  - tlast on word 63, wf_length=128: length_err=1, samples 64..127 are zero.
  - 200-word frame, wf_length=128: play_done at sample 127, FLUSH drops 72 words, then PRIME.
- Edge cases:
  - wf_length=0: play_done one cycle after trigger, no valid.
  - Trigger during PLAY: ignored, sample count unchanged.
- Reset mid-PLAY at sample 40: all outputs 0 immediately (async), FIFO empty, no play_done; normal play after reset release.
